// File: rtl/fft_peak_detector.sv
// fft_peak_detector
// Consumes a complex FFT output stream and computes |X|^2 for every bin in two
// register stages. It tracks the strongest bin of each 2^LOGN-sample frame and
// presents {index, magnitude} on a result port. An irq pulse marks each new
// result.
//
// Handshake semantics (both ports):
//   - A transfer happens on a rising clock edge where valid && ready are both high.
//   - A producer holding valid keeps its data stable until that transfer.
//   - Ready may depend combinationally on registered state and on res_ready_i.
//     Ready never depends on the valid of the same port.
module fft_peak_detector #(
  parameter int DATA_W = 16,
  parameter int LOGN   = 10,
  localparam int MAG_W = 2*DATA_W+1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                fft_in_valid_i,
  output logic                fft_in_ready_o,
  input  logic [2*DATA_W-1:0] fft_in_data_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [LOGN-1:0]     res_idx_o,
  output logic [MAG_W-1:0]    res_mag_o,
  output logic                irq_o
);

  localparam int PROD_W = 2*DATA_W;

  // Stage registers
  logic              s1_valid_q;
  logic [PROD_W-1:0] s1_re2_q;
  logic [PROD_W-1:0] s1_im2_q;
  logic [LOGN-1:0]   s1_idx_q;
  logic              s1_last_q;

  logic              s2_valid_q;
  logic [MAG_W-1:0]  s2_mag_q;
  logic [LOGN-1:0]   s2_idx_q;
  logic              s2_last_q;

  logic [LOGN-1:0]   bin_q;

  // Running peak of the current frame
  logic [MAG_W-1:0]  max_q;
  logic [LOGN-1:0]   max_idx_q;

  // Result port registers
  logic              res_valid_q;
  logic [LOGN-1:0]   res_idx_q;
  logic [MAG_W-1:0]  res_mag_q;
  logic              irq_q;

  // Combinational helpers
  logic                     en;
  logic                     accept;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic signed [PROD_W-1:0] re_ext;
  logic signed [PROD_W-1:0] im_ext;
  logic signed [PROD_W-1:0] re_sq;
  logic signed [PROD_W-1:0] im_sq;
  logic [MAG_W-1:0]         mag_d;
  logic                     take_d;
  logic [MAG_W-1:0]         trk_mag_d;
  logic [LOGN-1:0]          trk_idx_d;

  // The only back-pressure: a frame's last item sits in S2 and the previous
  // result is still unconsumed, so the whole pipe freezes.
  assign en             = !(s2_valid_q && s2_last_q && res_valid_q && !res_ready_i);
  assign fft_in_ready_o = en;
  assign accept         = fft_in_valid_i && en;

  assign in_re  = fft_in_data_i[2*DATA_W-1:DATA_W];
  assign in_im  = fft_in_data_i[DATA_W-1:0];
  assign re_ext = {{DATA_W{in_re[DATA_W-1]}}, in_re};
  assign im_ext = {{DATA_W{in_im[DATA_W-1]}}, in_im};
  // A square of a DATA_W-bit signed value is non-negative.
  // Its largest value is 2^(2*DATA_W-2), so it fits unsigned in PROD_W bits.
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  // One spare bit absorbs the carry of the sum, so there is no overflow.
  assign mag_d  = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};

  // Bin 0 always seeds the frame's peak.
  // After that only a strictly larger magnitude wins, so ties keep the lower index.
  assign take_d    = (s2_idx_q == '0) || (s2_mag_q > max_q);
  assign trk_mag_d = take_d ? s2_mag_q : max_q;
  assign trk_idx_d = take_d ? s2_idx_q : max_idx_q;

  // Squaring stage, magnitude stage and bin counter; all hold while en is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_re2_q   <= '0;
      s1_im2_q   <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mag_q   <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      bin_q      <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      bin_q      <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_re2_q  <= re_sq;
        s1_im2_q  <= im_sq;
        s1_idx_q  <= bin_q;
        s1_last_q <= (bin_q == {LOGN{1'b1}});
        bin_q     <= bin_q + LOGN'(1);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mag_q  <= mag_d;
        s2_idx_q  <= s1_idx_q;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Peak tracker and result register with its one-cycle interrupt pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q       <= '0;
      max_idx_q   <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_mag_q   <= '0;
      irq_q       <= 1'b0;
    end else if (clear_i) begin
      max_q       <= '0;
      max_idx_q   <= '0;
      res_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (res_valid_q && res_ready_i) begin
        res_valid_q <= 1'b0;
      end
      if (en && s2_valid_q) begin
        if (s2_last_q) begin
          // Publish the frame result and re-arm the tracker on the same edge.
          // A result popped on this edge is replaced rather than dropped.
          res_idx_q   <= trk_idx_d;
          res_mag_q   <= trk_mag_d;
          res_valid_q <= 1'b1;
          irq_q       <= 1'b1;
          max_q       <= '0;
          max_idx_q   <= '0;
        end else begin
          max_q     <= trk_mag_d;
          max_idx_q <= trk_idx_d;
        end
      end
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_idx_o   = res_idx_q;
  assign res_mag_o   = res_mag_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector.
// The main instance uses the default LOGN=10 and a second instance uses LOGN=3
// to exercise back-to-back frames at counter wrap.
module tb_fft_peak_detector;

  localparam int DW  = 16;
  localparam int LN  = 10;
  localparam int SLN = 3;
  localparam int MW  = 2*DW+1;

  // Clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // Main DUT signals
  logic            clear_i   = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] in_data   = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [LN-1:0]   res_idx;
  logic [MW-1:0]   res_mag;
  logic            irq;

  // Small DUT signals
  logic            s_clear     = 1'b0;
  logic            s_valid     = 1'b0;
  logic            s_ready;
  logic [2*DW-1:0] s_data      = '0;
  logic            s_res_valid;
  logic            s_res_ready = 1'b1;
  logic [SLN-1:0]  s_res_idx;
  logic [MW-1:0]   s_res_mag;
  logic            s_irq;

  fft_peak_detector #(.DATA_W(DW), .LOGN(LN)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .fft_in_valid_i (in_valid),
    .fft_in_ready_o (in_ready),
    .fft_in_data_i  (in_data),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_idx_o      (res_idx),
    .res_mag_o      (res_mag),
    .irq_o          (irq)
  );

  fft_peak_detector #(.DATA_W(DW), .LOGN(SLN)) dut_small (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (s_clear),
    .fft_in_valid_i (s_valid),
    .fft_in_ready_o (s_ready),
    .fft_in_data_i  (s_data),
    .res_valid_o    (s_res_valid),
    .res_ready_i    (s_res_ready),
    .res_idx_o      (s_res_idx),
    .res_mag_o      (s_res_mag),
    .irq_o          (s_irq)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [LN+MW-1:0]  got_q[$];
  logic [SLN+MW-1:0] s_got_q[$];
  int acc_cnt   = 0;
  int irq_cnt   = 0;
  int s_acc_cnt = 0;
  int s_irq_cnt = 0;

  logic signed [DW-1:0] re_a [1024];
  logic signed [DW-1:0] im_a [1024];

  // Observe completed result transfers, accepted samples and irq pulses
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (res_valid && res_ready) got_q.push_back({res_idx, res_mag});
      if (in_valid && in_ready) acc_cnt++;
      if (irq) irq_cnt++;
      if (s_res_valid && s_res_ready) s_got_q.push_back({s_res_idx, s_res_mag});
      if (s_valid && s_ready) s_acc_cnt++;
      if (s_irq) s_irq_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic fill(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    for (int i = 0; i < 1024; i++) begin
      re_a[i] = re;
      im_a[i] = im;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  // in_valid stays high so consecutive calls stream without gaps.
  task automatic send_sample(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = {re, im};
    while (!acc && guard < 5000) begin
      #1;
      acc = in_ready;
      @(negedge clk_i);
      guard++;
    end
    if (!acc) check("send_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_sample(re_a[i], im_a[i]);
  endtask

  task automatic wait_result(input string tag, input int exp_idx, input logic [MW-1:0] exp_mag);
    logic [LN+MW-1:0] r;
    int g;
    g = 0;
    while (got_q.size() == 0 && g < 3000) begin
      @(negedge clk_i);
      g++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 64'(got_q.size()), 64'd1);
    end else begin
      r = got_q.pop_front();
      check({tag, "_idx"}, 64'(r[LN+MW-1:MW]), 64'(exp_idx));
      check({tag, "_mag"}, 64'(r[MW-1:0]), 64'(exp_mag));
    end
  endtask

  int base;
  int irq_base;
  logic signed [DW-1:0] sre [16];
  logic signed [DW-1:0] sim [16];
  int s_stalls;
  logic [SLN+MW-1:0] sr;

  initial begin
    // Reset
    repeat (3) @(negedge clk_i);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_idx",   64'(res_idx),   64'd0);
    check("rst_res_mag",   64'(res_mag),   64'd0);
    check("rst_irq",       64'(irq),       64'd0);
    rst_ni = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk_i);

    // Test 1: single peak at bin 5, latency and irq width
    fill(0, 0);
    re_a[5] = 16'sd100;
    im_a[5] = -16'sd200;
    irq_base = irq_cnt;
    send_range(0, 1022);
    in_data = {re_a[1023], im_a[1023]};
    #1;
    check("t1_last_ready", 64'(in_ready), 64'd1);
    @(negedge clk_i);
    in_valid = 1'b0;
    #1;
    check("t1_lat_t1", 64'(res_valid), 64'd0);
    @(negedge clk_i);
    #1;
    check("t1_lat_t2", 64'(res_valid), 64'd0);
    @(negedge clk_i);
    #1;
    check("t1_lat_t3_valid", 64'(res_valid), 64'd1);
    check("t1_lat_t3_irq",   64'(irq),       64'd1);
    check("t1_res_idx",      64'(res_idx),   64'd5);
    check("t1_res_mag",      64'(res_mag),   64'd50000);
    @(negedge clk_i);
    #1;
    check("t1_irq_drop", 64'(irq),       64'd0);
    check("t1_popped",   64'(res_valid), 64'd0);
    check("t1_irq_count", 64'(irq_cnt - irq_base), 64'd1);
    wait_result("t1", 5, 33'd50000);
    @(negedge clk_i);

    // Test 2: most negative components on the last bin
    fill(16'sd1, 16'sd1);
    re_a[1023] = -16'sd32768;
    im_a[1023] = -16'sd32768;
    send_range(0, 1023);
    in_valid = 1'b0;
    wait_result("t2", 1023, 33'h0_8000_0000);

    // Test 3: equal peaks at bins 3 and 7, the lower index wins
    fill(0, 0);
    re_a[3] = 16'sd3; im_a[3] = 16'sd4;
    re_a[7] = 16'sd3; im_a[7] = 16'sd4;
    send_range(0, 1023);
    in_valid = 1'b0;
    wait_result("t3", 3, 33'd25);
    repeat (4) @(negedge clk_i);

    // Test 4: result held while the next frame streams
    res_ready = 1'b0;
    fill(0, 0);
    re_a[50] = 16'sd300; im_a[50] = 16'sd400;
    send_range(0, 1023);
    base = acc_cnt;
    fill(0, 0);
    re_a[200] = 16'sd0; im_a[200] = 16'sd1000;
    send_range(0, 1023);
    // Next frame's bin 0 is still accepted before the last item reaches S2
    send_sample(16'sd0, 16'sd0);
    fill(0, 0);
    re_a[10] = 16'sd1000;
    in_data = {re_a[1], im_a[1]};
    #1;
    check("t4_stall_ready", 64'(in_ready), 64'd0);
    repeat (5) @(negedge clk_i);
    #1;
    check("t4_still_stalled", 64'(in_ready), 64'd0);
    check("t4_no_pop", 64'(got_q.size()), 64'd0);
    check("t4_accepted", 64'(acc_cnt - base), 64'd1025);
    check("t4_held_idx", 64'(res_idx), 64'd50);
    @(negedge clk_i);
    res_ready = 1'b1;
    send_range(1, 299);
    in_valid = 1'b0;
    wait_result("t4_a", 50, 33'd250000);
    wait_result("t4_b", 200, 33'd1000000);
    check("t4_total_acc", 64'(acc_cnt - base), 64'd1324);

    // Test 5a: clear mid-frame with a discarded sample on the same cycle
    @(negedge clk_i);
    clear_i  = 1'b1;
    in_valid = 1'b1;
    in_data  = {16'sh7fff, 16'sh7fff};
    @(negedge clk_i);
    clear_i  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_clear_valid", 64'(res_valid), 64'd0);
    check("t5_clear_irq",   64'(irq),       64'd0);
    @(negedge clk_i);
    fill(0, 0);
    re_a[600] = -16'sd500; im_a[600] = 16'sd7;
    send_range(0, 1023);
    in_valid = 1'b0;
    wait_result("t5", 600, 33'd250049);
    check("t5_no_extra", 64'(got_q.size()), 64'd0);

    // Test 5b: asynchronous reset in the middle of a frame
    fill(0, 0);
    send_range(0, 99);
    in_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("t5r_valid", 64'(res_valid), 64'd0);
    check("t5r_idx",   64'(res_idx),   64'd0);
    check("t5r_mag",   64'(res_mag),   64'd0);
    check("t5r_irq",   64'(irq),       64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("t5r_ready", 64'(in_ready), 64'd1);
    @(negedge clk_i);
    fill(0, 0);
    re_a[2] = 16'sd5; im_a[2] = 16'sd5;
    send_range(0, 1023);
    in_valid = 1'b0;
    wait_result("t5r", 2, 33'd50);

    // Test 6: LOGN=3, two back-to-back frames
    for (int i = 0; i < 16; i++) begin
      sre[i] = (i < 8) ? 16'sd1 : 16'sd2;
      sim[i] = (i < 8) ? 16'sd0 : 16'sd2;
    end
    sre[7] = 16'sd10; sim[7] = 16'sd0;
    sre[8] = 16'sd0;  sim[8] = 16'sd20;
    s_stalls = 0;
    base = s_acc_cnt;
    irq_base = s_irq_cnt;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = {sre[i], sim[i]};
      #1;
      if (!s_ready) s_stalls++;
      @(negedge clk_i);
    end
    s_valid = 1'b0;
    repeat (6) @(negedge clk_i);
    check("t6_no_bubble", 64'(s_stalls), 64'd0);
    check("t6_accepted", 64'(s_acc_cnt - base), 64'd16);
    check("t6_irqs", 64'(s_irq_cnt - irq_base), 64'd2);
    check("t6_count", 64'(s_got_q.size()), 64'd2);
    if (s_got_q.size() > 0) begin
      sr = s_got_q.pop_front();
      check("t6_f0_idx", 64'(sr[SLN+MW-1:MW]), 64'd7);
      check("t6_f0_mag", 64'(sr[MW-1:0]), 64'd100);
    end
    if (s_got_q.size() > 0) begin
      sr = s_got_q.pop_front();
      check("t6_f1_idx", 64'(sr[SLN+MW-1:MW]), 64'd0);
      check("t6_f1_mag", 64'(sr[MW-1:0]), 64'd400);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Downstream consumer of the FFT subordinate's exported output stream (fft_out_valid_o/fft_out_data_o/fft_out_ready_i) in the user domain.
- Computes |X|^2 per bin in a 2-stage pipeline and tracks the peak bin over each 2^LOGN-sample frame.
- Presents {peak index, peak magnitude} on a valid/ready result port and pulses an interrupt line routed to interrupts_o.

Parameters:
- DATA_W, 16: width of each signed Re/Im component.
- LOGN, 10: log2 of frame length; the bin index is LOGN bits.
- MAG_W (localparam), 2*DATA_W+1: magnitude-squared width.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous frame restart/flush
- fft_in_valid_i  in  1  input sample valid
- fft_in_ready_o  out  1  input sample ready
- fft_in_data_i  in  2*DATA_W  {Re[2*DATA_W-1:DATA_W], Im[DATA_W-1:0]}, signed two's complement
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_idx_o  out  LOGN  peak bin index
- res_mag_o  out  MAG_W  peak Re^2+Im^2, unsigned
- irq_o  out  1  one-cycle pulse when a result is loaded

Behaviour:
- Reset (async, rst_ni low): all pipeline valids = 0, bin counter = 0, running max = 0, res_valid_o = 0, res_idx_o = 0, res_mag_o = 0, irq_o = 0. fft_in_ready_o = 1 from the first cycle after reset release.
- Pipeline enable: en = !(s2_valid && s2_last && res_valid_o && !res_ready_i). fft_in_ready_o = en (combinational). When en = 0, all stages hold.
- Accept (valid && ready at edge t):
  - S1 registers Re*Re and Im*Im (each 2*DATA_W bits, unsigned), the bin index, and last = (bin == 2^LOGN-1).
  - Bin counter increments, wrapping 2^LOGN-1 -> 0.
- S2 (valid from t+2): registers mag = Re^2 + Im^2, zero-extended to MAG_W, with no overflow. Worst case: (-2^(DATA_W-1))^2 * 2 = 2^(2*DATA_W-1).
- Tracker (consumes S2 at an enabled edge):
  - If the S2 item is the first bin of a frame, or mag > max strictly: load max <- mag, max_idx <- idx.
  - Ties keep the lower index.
- Frame end (consumed S2 item has last = 1):
  - res_idx_o/res_mag_o are loaded with the final max, including the last item's contribution.
  - res_valid_o = 1 and irq_o = 1 for exactly one cycle.
  - Latency: last sample accepted at edge t -> res_valid_o high in cycle t+3.
  - The tracker re-arms for the next frame in the same edge.
- Result handshake: res_valid_o stays high with stable data until res_valid_o && res_ready_i.
  - If a new result loads on the same edge the old one is accepted, res_valid_o stays 1 with the new data and irq_o pulses.
  - The stall only engages when the next last item reaches S2 while a result is still held. Streaming continues otherwise, and no sample is ever dropped.
- clear_i (sync, highest priority):
  - Clears S1/S2 valids, bin counter, running max, res_valid_o and irq_o.
  - A sample handshaken in the same cycle is discarded.
  - The next accepted sample is bin 0.
- Non-power-of-two frames are not supported. Frame boundaries come from the bin counter only.

Test Plan:
1. One frame with all bins 0 except bin 5 = (Re 100, Im -200) -> res_idx_o = 5, res_mag_o = 50000, res_valid_o high 3 cycles after the last accept, irq_o high exactly 1 cycle.
2. Bin 1023 = (-32768, -32768), all others (1,1) -> res_idx_o = 1023, res_mag_o = 33'h0_8000_0000; confirms sign handling and width.
3. Bins 3 and 7 both (3,4), rest 0 -> res_idx_o = 3, res_mag_o = 25 (tie keeps lower index).
4. res_ready_i held 0 after frame 1 while frame 2 streams with constant valid -> fft_in_ready_o drops when frame 2's last sample reaches S2. After res_ready_i: frame 1 result pops, frame 2 result (peak at bin 200 = (0,1000), mag 1000000) appears next, and all 1024 samples are accepted exactly once.
5. clear_i pulsed after 300 samples (peak planted at bin 10), then a full frame with peak at bin 600 -> result idx 600. Separately, rst_ni low mid-frame -> all outputs 0 and a fresh frame produces a correct result.
6. LOGN = 3 build, two back-to-back 8-sample frames with peaks at bins 7 and 0 -> results idx 7 then idx 0; the counter wraps 7->0 with no bubble.
